link_upstream_mc: RTL
=====================

# link_upstream_mc

Parametrised multi-channel upstream link serializer. Accepts one CORE_W-bit word per valid/ready handshake from the core, slices it into CH_W-bit beats across CH_NUM parallel channels, and streams them toward the I/O side. Each channel has credit-based flow control with token returns from the far side. A narrow mode runs on half the channels when the link is degraded. It replaces the fixed 64-bit/2-channel upstream datapath.

## Interface
- CORE_W, 64, core word width; multiple of CH_NUM*CH_W.
- CH_NUM, 2, physical channel count; even, ≥2.
- CH_W, 8, bits per channel per beat.
- CREDITS, 8, per-channel credit capacity; ≥1.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- core_valid_i  in  1  core word valid.
- core_data_i  in  CORE_W  core word.
- core_ready_o  out  1  word accepted when valid&ready.
- narrow_i  in  1  1 = use channels 0..CH_NUM/2-1 only; sampled at accept.
- io_ready_i  in  1  I/O side can take a beat this cycle.
- io_valid_o  out  CH_NUM  per-channel beat valid.
- io_data_o  out  CH_NUM*CH_W  channel c at bits [c*CH_W +: CH_W].
- token_i  in  CH_NUM  one-cycle pulse returns one credit to channel c.
- credit_err_o  out  1  sticky: token returned to a full counter.

## Operation
- Derived values: CH_ACT = CH_NUM (wide) or CH_NUM/2 (narrow); BEATS = CORE_W/(CH_ACT*CH_W). Defaults give 4 beats wide, 8 beats narrow.
- FSM states:
  - IDLE: core_ready_o=1. On accept, latch data and mode, clear beat_cnt, go to SEND.
  - SEND: a beat fires when io_ready_i=1 and every active channel has credit ≥1.
- Beat firing:
  - On fire, io_valid_o[c]=1 for active channels only; inactive channels stay 0 with data 0.
  - Each active channel decrements its credit by 1, and beat_cnt increments.
- Beat mapping: beat k, active channel c carries core word bits [(k*CH_ACT+c)*CH_W +: CH_W], little-endian: word bit 0 leaves first on channel 0.
- Last beat (beat_cnt==BEATS-1 and firing):
  - core_ready_o=1 in that cycle.
  - If core_valid_i, accept the next word back-to-back and stay in SEND with beat_cnt=0 and the new narrow_i.
  - Otherwise go to IDLE.
- Credits:
  - Per-channel counters, width $clog2(CREDITS+1).
  - token_i[c] increments the counter.
  - Decrement and token in the same cycle leave the count unchanged.
  - A token at count==CREDITS with no decrement saturates the count and sets credit_err_o until reset.
  - Inactive channels in narrow mode still accept tokens.
- Mode changes: narrow_i has no effect mid-word.

## Timing
- Reset values:
  - State IDLE; core_ready_o=1 once out of reset.
  - io_valid_o=0, io_data_o=0.
  - All credits = CREDITS; credit_err_o=0.
- Reset assertion mid-word drops the word silently. Outputs return to reset values asynchronously.
- io_valid_o and io_data_o are combinational from registered state, io_ready_i and credit counts. There are no other combinational paths from core_valid_i to io_valid_o.
- Latency: word accepted at cycle t; first beat can fire at t+1.
- Minimum cycles per word: BEATS, with back-to-back words giving no bubble.
- A stall (io_ready_i=0 or missing credit) holds the beat, beat_cnt and data unchanged. io_valid_o=0 during a stall.
- Credit granularity: one stalled channel stalls all active channels, so beats stay lockstep.

## Structure
- Shared package link_pkg:
  - State enum {IDLE, SEND}.
  - Function beats(core_w, ch_act, ch_w).
  - Function credit_width(credits).
- Sub-module link_credit_counter: one instance per channel, generated CH_NUM times.
  - Ports: clk, rst, dec_i, inc_i, avail_o, err_o.
  - Saturating counter with the sticky-error rule.
- Top-level: FSM, beat counter, word shift/mux, error OR-reduction.

## Test plan
- Wide send, defaults, credits full, io_ready_i=1. Word 0x0807060504030201 accepted at t.
  - Required: t+1..t+4 ch0/ch1 = 01/02, 03/04, 05/06, 07/08.
  - core_ready_o=1 at t+4.
- Narrow send of the same word.
  - Required: 8 beats on ch0 only (01..08); io_valid_o[1]=0 throughout.
- Credit starvation: CREDITS=2, no tokens, send one wide word.
  - Required: 2 beats fire, then stall with io_valid_o=0.
  - A token pulse on ch0 only keeps the stall; a token on ch1 resumes the 3rd beat next cycle.
- Back-to-back: two words with core_valid_i held.
  - Required: 8 consecutive beats, no bubble; second word accepted in the cycle of the first word's 4th beat.
- Token overflow: token_i[1] pulse with full credits.
  - Required: credit_err_o=1 next cycle and stays 1; ch1 count stays 8.
  - Simultaneous token and beat on ch0 leaves its count unchanged.
- Reset mid-word: rst low after beat 2.
  - Required: io_valid_o=0 immediately, credits back to 8, core_ready_o=1 after release.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and sizing helpers for the multi-channel upstream link serializer.
package link_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic int beats(input int core_w, input int ch_act, input int ch_w);
        return core_w / (ch_act * ch_w);
    endfunction

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/link_credit_counter.sv
// Per-channel saturating credit counter with a sticky overflow flag.
module link_credit_counter
    import link_pkg::*;
#(
    parameter int CREDITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dec_i,
    input  logic inc_i,
    output logic avail_o,
    output logic err_o
);

    localparam int CNT_W = credit_width(CREDITS);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] cnt;

    // A token and a spend in the same cycle cancel; a token on a full counter only flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= FULL;
            err_o <= 1'b0;
        end else if (inc_i && !dec_i) begin
            if (cnt == FULL)
                err_o <= 1'b1;
            else
                cnt <= cnt + CNT_W'(1);
        end else if (dec_i && !inc_i && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign avail_o = (cnt != '0);

endmodule

// File: rtl/link_upstream_mc.sv
// Upstream link serializer: slices core words into lockstep beats over CH_NUM credited channels.
module link_upstream_mc
    import link_pkg::*;
#(
    parameter int CORE_W  = 64,
    parameter int CH_NUM  = 2,
    parameter int CH_W    = 8,
    parameter int CREDITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_valid_i,
    input  logic [CORE_W-1:0]      core_data_i,
    output logic                   core_ready_o,
    input  logic                   narrow_i,
    input  logic                   io_ready_i,
    output logic [CH_NUM-1:0]      io_valid_o,
    output logic [CH_NUM*CH_W-1:0] io_data_o,
    input  logic [CH_NUM-1:0]      token_i,
    output logic                   credit_err_o
);

    localparam int HALF      = CH_NUM / 2;
    localparam int BEATS_W   = beats(CORE_W, CH_NUM, CH_W);
    localparam int BEATS_N   = beats(CORE_W, HALF, CH_W);
    localparam int BCNT_W    = $clog2(BEATS_N + 1);
    localparam int WIDE_BITS = CH_NUM * CH_W;
    localparam int HALF_BITS = HALF * CH_W;
    localparam logic [BCNT_W-1:0] LAST_W = BCNT_W'(BEATS_W - 1);
    localparam logic [BCNT_W-1:0] LAST_N = BCNT_W'(BEATS_N - 1);

    state_t              state;
    logic                narrow_q;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [CORE_W-1:0]   word;
    logic [CH_NUM-1:0]   act_mask;
    logic [CH_NUM-1:0]   avail;
    logic [CH_NUM-1:0]   err;
    logic                fire;
    logic                last;
    logic                accept;

    always_comb begin
        act_mask = '0;
        for (int c = 0; c < CH_NUM; c++)
            act_mask[c] = !narrow_q || (c < HALF);
    end

    // Every active channel must hold a credit, so all active lanes advance together.
    assign fire         = (state == SEND) && io_ready_i && (&(avail | ~act_mask));
    assign last         = fire && (beat_cnt == (narrow_q ? LAST_N : LAST_W));
    assign core_ready_o = (state == IDLE) || last;
    assign accept       = core_valid_i && core_ready_o;

    assign io_valid_o = fire ? act_mask : '0;

    always_comb begin
        io_data_o = '0;
        for (int c = 0; c < CH_NUM; c++)
            if (fire && act_mask[c])
                io_data_o[c*CH_W +: CH_W] = word[c*CH_W +: CH_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            narrow_q <= 1'b0;
            beat_cnt <= '0;
        end else if (accept) begin
            state    <= SEND;
            narrow_q <= narrow_i;
            beat_cnt <= '0;
        end else if (last) begin
            state    <= IDLE;
        end else if (fire) begin
            beat_cnt <= beat_cnt + BCNT_W'(1);
        end
    end

    // The word shifts down after each beat so the current beat always sits at the bottom.
    always_ff @(posedge clk) begin
        if (accept)
            word <= core_data_i;
        else if (fire)
            word <= narrow_q ? (word >> HALF_BITS) : (word >> WIDE_BITS);
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_credit
        link_credit_counter #(.CREDITS(CREDITS)) u_credit (
            .clk    (clk),
            .rst    (rst),
            .dec_i  (fire & act_mask[c]),
            .inc_i  (token_i[c]),
            .avail_o(avail[c]),
            .err_o  (err[c])
        );
    end

    assign credit_err_o = |err;

endmodule
